// File: rtl/prewish5k_pkg.sv
// Shared types for the prewish5k mask path: arbiter FSM encoding and mask width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prewish5k_pkg;

    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LATCH  = 2'b01,
        ST_STROBE = 2'b11,
        ST_HOLD   = 2'b10
    } arb_state_t;

    // Next index in a ring of n entries; explicit compare so n need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prewish5k_rr_pick.sv
// Rotating-priority picker: first set request scanning last+1, last+2, ... with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the pick.
module prewish5k_rr_pick
    import prewish5k_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   last,
    output logic            vld,
    output logic [PW-1:0]   win
);

    always_comb begin
        int idx;
        vld = 1'b0;
        win = '0;
        idx = int'(last);
        for (int i = 0; i < NREQ; i++) begin
            idx = wrap_inc(idx, NREQ);
            if (!vld && req[idx]) begin
                vld = 1'b1;
                win = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/prewish5k_mask_arbiter.sv
// Round-robin share of the mentor mask-load port; one strobe per grant, then HOLDOFF idle cycles.
// Latency: REQ seen in IDLE at T -> STB_O/ACK_O at T+2; strobes at least HOLDOFF+3 apart.
// Backpressure: requests are levels held until ACK_O; only sampled in IDLE.
module prewish5k_mask_arbiter
    import prewish5k_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = MASK_W,
    parameter int HOLDOFF    = 1024,
    parameter int ALIVE_BITS = 22
) (
    input  logic               CLK_I,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ_I,
    input  logic [NREQ*DW-1:0] DAT_I,
    output logic [NREQ-1:0]    ACK_O,
    output logic               STB_O,
    output logic [DW-1:0]      DAT_O,
    output logic [NREQ-1:0]    GNT_O,
    output logic               BUSY_O,
    output logic               o_alive
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(HOLDOFF + 1);

    arb_state_t            state;
    logic [PW-1:0]         last_q;
    logic [PW-1:0]         win_q;
    logic [CW-1:0]         hold_ct;
    logic [ALIVE_BITS-1:0] alive_ct;

    logic                  pick_vld;
    logic [PW-1:0]         pick_win;
    logic [NREQ-1:0]       win_oh;

    prewish5k_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (REQ_I),
        .last (last_q),
        .vld  (pick_vld),
        .win  (pick_win)
    );

    always_comb begin
        win_oh = '0;
        win_oh[win_q] = 1'b1;
    end

    always_ff @(posedge CLK_I or negedge RST_N) begin
        if (!RST_N) begin
            alive_ct <= '0;
        end else begin
            alive_ct <= alive_ct + 1'b1;
        end
    end

    assign o_alive = alive_ct[ALIVE_BITS-1];

    // last_q resets to NREQ-1 so requester 0 wins the first scan.
    always_ff @(posedge CLK_I or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            last_q  <= PW'(NREQ - 1);
            win_q   <= '0;
            hold_ct <= '0;
            STB_O   <= 1'b0;
            ACK_O   <= '0;
            DAT_O   <= '0;
            GNT_O   <= '0;
            BUSY_O  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_q  <= pick_win;
                        BUSY_O <= 1'b1;
                        state  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    DAT_O  <= DAT_I[win_q*DW +: DW];
                    GNT_O  <= win_oh;
                    ACK_O  <= win_oh;
                    STB_O  <= 1'b1;
                    last_q <= win_q;
                    state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    STB_O   <= 1'b0;
                    ACK_O   <= '0;
                    hold_ct <= CW'(HOLDOFF - 1);
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_ct == '0) begin
                        BUSY_O <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        hold_ct <= hold_ct - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
